// File: rtl/data_compress_pkg.sv
// data_compress_pkg: definitions shared by data_compress and data_pack.
//   DEF_DW / DEF_N : default lane width and lanes per beat
//   occ_t          : buffer occupancy count for the default N (0..2N)
//   pack_state_t   : data_pack control states
package data_compress_pkg;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_N  = 8;
  localparam int unsigned OCC_W  = $clog2(2 * DEF_N + 1);

  typedef logic [OCC_W-1:0] occ_t;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

endpackage

// File: rtl/data_pack_lane_popcount.sv
// lane_popcount: counts the set bits of an N-bit lane-valid vector.
// Purely combinational.
//   valid_i : per-lane valid flags
//   cnt_o   : number of set flags (0..N)
module lane_popcount
  import data_compress_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  valid_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cnt_o = cnt_o + CW'(valid_i[k]);
    end
  end

endmodule

// File: rtl/data_pack.sv
// data_pack: packs variable-count compacted lanes (0..N per cycle, from lane 0)
// into dense N-lane output beats through a 2N-entry buffer. A flush request
// drains a trailing partial beat, marked by o_keep.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : per-lane input valid (thermometer from lane 0)
//   i_data     : input lanes
//   i_ready    : input accepted this cycle (registers only)
//   i_flush    : request to emit any residual partial beat
//   o_valid    : output beat valid
//   o_ready    : downstream accepts beat
//   o_data     : output beat, lane 0 oldest
//   o_keep     : per-lane valid of the output beat
// Optional: define DATA_PACK_ASSERT_EN to compile simulation assertions.
module data_pack
  import data_compress_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned N  = DEF_N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_valid,
  input  logic [DW-1:0] i_data [N-1:0],
  output logic          i_ready,
  input  logic          i_flush,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data [N-1:0],
  output logic [N-1:0]  o_keep
);

  localparam int unsigned OW = $clog2(2 * N + 1);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0] buf_q [2*N];
  logic [DW-1:0] buf_d [2*N];
  logic [OW-1:0] occ_q, occ_d;
  pack_state_t   state_q, state_d;

  logic [CW-1:0] cnt;
  logic          accept, drain;
  logic [OW-1:0] drained, base;
  int unsigned   occ_u, base_u, cnt_u;
  logic [IW-1:0] lane;

  lane_popcount #(.N(N), .CW(CW)) u_popcount (
    .valid_i (i_valid),
    .cnt_o   (cnt)
  );

  assign occ_u   = 32'(occ_q);
  assign i_ready = (state_q == FILL) && (occ_u <= N);
  assign o_valid = (state_q == FILL) ? (occ_u >= N) : (occ_q != '0);
  assign accept  = i_ready && (cnt != '0);
  assign drain   = o_valid && o_ready;
  assign drained = drain ? ((occ_u >= N) ? OW'(N) : occ_q) : '0;
  assign base    = occ_q - drained;
  assign base_u  = 32'(base);
  assign cnt_u   = 32'(cnt);

  // Entries at or above occ are always zero, so masking only matters for a
  // flush beat; it is kept explicit so a partial beat never exposes stale data.
  always_comb begin
    o_keep = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_keep[i] = o_valid && (i < occ_u);
      o_data[i] = ((state_q == FLUSH) && (i >= occ_u)) ? '0 : buf_q[i];
    end
  end

  // Shift first, then append after the surviving entries so a same-cycle
  // drain and accept land new lanes at the post-drain base.
  always_comb begin
    lane = '0;
    for (int unsigned i = 0; i < N; i++) begin
      buf_d[i] = drain ? buf_q[i+N] : buf_q[i];
    end
    for (int unsigned i = N; i < 2 * N; i++) begin
      buf_d[i] = drain ? '0 : buf_q[i];
    end
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (accept && (i >= base_u) && (i < base_u + cnt_u)) begin
        lane     = IW'(i - base_u);
        buf_d[i] = i_data[lane];
      end
    end
    occ_d = accept ? (base + OW'(cnt)) : base;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (i_flush) state_d = FLUSH;
      FLUSH:   if (occ_d == '0) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2 * N; i++) buf_q[i] <= '0;
      occ_q   <= '0;
      state_q <= FILL;
    end else begin
      for (int unsigned i = 0; i < 2 * N; i++) buf_q[i] <= buf_d[i];
      occ_q   <= occ_d;
      state_q <= state_d;
    end
  end

`ifdef DATA_PACK_ASSERT_EN
  logic [N*DW-1:0] o_data_flat;

  always_comb begin
    o_data_flat = '0;
    for (int unsigned k = 0; k < N; k++) o_data_flat[k*DW +: DW] = o_data[k];
  end

  a_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
    (i_valid != '0) |-> ((i_valid & (i_valid + N'(1))) == '0));

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ_u <= 2 * N);

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (o_valid && !o_ready) |=> ($stable(o_data_flat) && $stable(o_keep)));

  a_no_accept: assert property (@(posedge clk) disable iff (!rst_n)
    (!i_ready) |=> (occ_q <= $past(occ_q)));
`else
`endif

endmodule

// File: tb/tb_data_pack.sv
module tb_data_pack;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  i_valid;
  logic [DW-1:0] i_data [N-1:0];
  logic          i_ready;
  logic          i_flush;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data [N-1:0];
  logic [N-1:0]  o_keep;

  int cmp = 0;
  int bad = 0;

  logic [DW-1:0]   e [N-1:0];
  logic [N*DW-1:0] held;

  data_pack #(.DW(DW), .N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_keep  (o_keep)
  );

  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] flat(input logic [DW-1:0] a [N-1:0]);
    logic [N*DW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = a[k];
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Valid lanes get base+k; invalid lanes carry junk that must never be taken.
  task automatic drive(input logic [N-1:0] v, input logic [DW-1:0] b);
    i_valid = v;
    for (int k = 0; k < N; k++) i_data[k] = v[k] ? (b + DW'(k)) : (32'hBAD0_0000 | DW'(k));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_flush = 1'b0; o_ready = 1'b0;
    drive(8'h00, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    cmp++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    cmp++; if (o_keep !== 8'h00) begin bad++; $display("FAIL reset_o_keep: got %h want 00", o_keep); end
    cmp++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
    cmp++; if (flat(o_data) !== '0) begin bad++; $display("FAIL reset_o_data: got %h want 0", flat(o_data)); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    cmp++; if (i_ready !== 1'b1 || o_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got rdy=%b vld=%b want 1/0", i_ready, o_valid); end
  endtask

  task automatic test_partial_merge;
    o_ready = 1'b1;
    drive(8'h07, 32'd0);
    step();
    cmp++; if (o_valid !== 1'b0) begin bad++; $display("FAIL merge_partial_no_beat: got %b want 0", o_valid); end
    drive(8'h1F, 32'd10);
    step();
    drive(8'h00, 32'd0);
    e[0] = 0; e[1] = 1; e[2] = 2;
    for (int k = 3; k < 8; k++) e[k] = DW'(10 + k - 3);
    cmp++; if (o_valid !== 1'b1) begin bad++; $display("FAIL merge_o_valid: got %b want 1", o_valid); end
    cmp++; if (flat(o_data) !== flat(e)) begin bad++; $display("FAIL merge_o_data: got %h want %h", flat(o_data), flat(e)); end
    cmp++; if (o_keep !== 8'hFF) begin bad++; $display("FAIL merge_o_keep: got %h want ff", o_keep); end
    step();
    cmp++; if (o_valid !== 1'b0) begin bad++; $display("FAIL merge_drained_valid: got %b want 0", o_valid); end
    cmp++; if (dut.occ_q !== 5'd0) begin bad++; $display("FAIL merge_drained_occ: got %0d want 0", dut.occ_q); end
  endtask

  task automatic test_backpressure;
    o_ready = 1'b0;
    drive(8'hFF, 32'd100);
    step();
    cmp++; if (i_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_at_8: got %b want 1", i_ready); end
    drive(8'hFF, 32'd200);
    step();
    // Offered while i_ready is low: must be ignored.
    drive(8'hFF, 32'd999);
    for (int k = 0; k < 8; k++) e[k] = DW'(100 + k);
    cmp++; if (dut.occ_q !== 5'd16) begin bad++; $display("FAIL bp_occ16: got %0d want 16", dut.occ_q); end
    cmp++; if (i_ready !== 1'b0) begin bad++; $display("FAIL bp_not_ready: got %b want 0", i_ready); end
    cmp++; if (o_valid !== 1'b1 || flat(o_data) !== flat(e)) begin bad++; $display("FAIL bp_first_beat: got vld=%b %h want 1 %h", o_valid, flat(o_data), flat(e)); end
    held = flat(o_data);
    step();
    drive(8'h00, 32'd0);
    cmp++; if (flat(o_data) !== held) begin bad++; $display("FAIL bp_hold: got %h want %h", flat(o_data), held); end
    cmp++; if (dut.occ_q !== 5'd16) begin bad++; $display("FAIL bp_ignored_input: got occ %0d want 16", dut.occ_q); end
    o_ready = 1'b1;
    step();
    for (int k = 0; k < 8; k++) e[k] = DW'(200 + k);
    cmp++; if (o_valid !== 1'b1 || flat(o_data) !== flat(e)) begin bad++; $display("FAIL bp_second_beat: got vld=%b %h want 1 %h", o_valid, flat(o_data), flat(e)); end
    step();
    cmp++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin bad++; $display("FAIL bp_empty: got vld=%b rdy=%b want 0/1", o_valid, i_ready); end
  endtask

  task automatic test_flush_partial;
    o_ready = 1'b0;
    drive(8'h07, 32'hA);
    step();
    drive(8'h00, 32'd0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    e[0] = 32'hA; e[1] = 32'hB; e[2] = 32'hC;
    for (int k = 3; k < 8; k++) e[k] = '0;
    cmp++; if (o_valid !== 1'b1 || o_keep !== 8'h07) begin bad++; $display("FAIL flush_beat: got vld=%b keep=%h want 1 07", o_valid, o_keep); end
    cmp++; if (flat(o_data) !== flat(e)) begin bad++; $display("FAIL flush_data: got %h want %h", flat(o_data), flat(e)); end
    cmp++; if (i_ready !== 1'b0) begin bad++; $display("FAIL flush_not_ready: got %b want 0", i_ready); end
    step();
    cmp++; if (o_valid !== 1'b1 || o_keep !== 8'h07 || i_ready !== 1'b0) begin bad++; $display("FAIL flush_hold: got vld=%b keep=%h rdy=%b want 1 07 0", o_valid, o_keep, i_ready); end
    o_ready = 1'b1;
    step();
    cmp++; if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_keep !== 8'h00) begin bad++; $display("FAIL flush_done: got vld=%b rdy=%b keep=%h want 0 1 00", o_valid, i_ready, o_keep); end
    cmp++; if (dut.state_q !== 1'b0 || dut.occ_q !== 5'd0) begin bad++; $display("FAIL flush_fill_state: got st=%b occ=%0d want 0 0", dut.state_q, dut.occ_q); end
  endtask

  task automatic test_flush_empty;
    o_ready = 1'b1;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    cmp++; if (o_valid !== 1'b0 || i_ready !== 1'b0) begin bad++; $display("FAIL flush_empty_cycle: got vld=%b rdy=%b want 0 0", o_valid, i_ready); end
    step();
    cmp++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin bad++; $display("FAIL flush_empty_back: got vld=%b rdy=%b want 0 1", o_valid, i_ready); end
  endtask

  task automatic test_flush_multi;
    o_ready = 1'b0;
    drive(8'hFF, 32'd600);
    step();
    drive(8'h03, 32'd700);
    i_flush = 1'b1;
    step();
    drive(8'h00, 32'd0);
    i_flush = 1'b0;
    for (int k = 0; k < 8; k++) e[k] = DW'(600 + k);
    cmp++; if (o_valid !== 1'b1 || o_keep !== 8'hFF || flat(o_data) !== flat(e)) begin bad++; $display("FAIL fmulti_full: got vld=%b keep=%h %h want 1 ff %h", o_valid, o_keep, flat(o_data), flat(e)); end
    o_ready = 1'b1;
    step();
    e[0] = 32'd700; e[1] = 32'd701;
    for (int k = 2; k < 8; k++) e[k] = '0;
    cmp++; if (o_valid !== 1'b1 || o_keep !== 8'h03 || flat(o_data) !== flat(e)) begin bad++; $display("FAIL fmulti_tail: got vld=%b keep=%h %h want 1 03 %h", o_valid, o_keep, flat(o_data), flat(e)); end
    step();
    cmp++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin bad++; $display("FAIL fmulti_done: got vld=%b rdy=%b want 0 1", o_valid, i_ready); end
  endtask

  task automatic test_drain_accept;
    o_ready = 1'b1;
    drive(8'hFF, 32'd300);
    step();
    drive(8'h0F, 32'hD0);
    cmp++; if (o_valid !== 1'b1) begin bad++; $display("FAIL da_beat: got %b want 1", o_valid); end
    step();
    cmp++; if (o_valid !== 1'b0 || dut.occ_q !== 5'd4) begin bad++; $display("FAIL da_occ4: got vld=%b occ=%0d want 0 4", o_valid, dut.occ_q); end
    drive(8'h0F, 32'hE0);
    step();
    drive(8'h00, 32'd0);
    for (int k = 0; k < 4; k++) begin e[k] = 32'hD0 + DW'(k); e[k+4] = 32'hE0 + DW'(k); end
    cmp++; if (o_valid !== 1'b1 || flat(o_data) !== flat(e)) begin bad++; $display("FAIL da_merged: got vld=%b %h want 1 %h", o_valid, flat(o_data), flat(e)); end
    step();
  endtask

  task automatic test_reset_mid;
    o_ready = 1'b1;
    drive(8'h1F, 32'd400);
    step();
    drive(8'h00, 32'd0);
    cmp++; if (o_data[0] !== 32'd400) begin bad++; $display("FAIL rm_pre: got %h want %h", o_data[0], 32'd400); end
    #2;
    rst_n = 1'b0;
    #1;
    cmp++; if (o_valid !== 1'b0 || o_keep !== 8'h00 || i_ready !== 1'b1) begin bad++; $display("FAIL rm_async: got vld=%b keep=%h rdy=%b want 0 00 1", o_valid, o_keep, i_ready); end
    cmp++; if (flat(o_data) !== '0 || dut.occ_q !== 5'd0) begin bad++; $display("FAIL rm_cleared: got %h occ=%0d want 0 0", flat(o_data), dut.occ_q); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hFF, 32'd500);
    step();
    drive(8'h00, 32'd0);
    for (int k = 0; k < 8; k++) e[k] = DW'(500 + k);
    cmp++; if (o_valid !== 1'b1 || o_keep !== 8'hFF || flat(o_data) !== flat(e)) begin bad++; $display("FAIL rm_post_beat: got vld=%b keep=%h %h want 1 ff %h", o_valid, o_keep, flat(o_data), flat(e)); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_partial_merge();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_multi();
    test_drain_accept();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
